traffic_light_ctrl: RTL and testbench
=====================================

# traffic_light_ctrl

Parametrised N-approach traffic-signal controller. It sequences GREEN → YELLOW → ALL-RED clearance around NUM_DIR approaches in round-robin order, with programmable phase durations counted on an external timebase strobe. It also provides demand-actuated skipping, rest-in-green when no other approach is waiting, and a night/fault flashing-yellow mode. It sits between the intersection timebase and sensor front-end and the lamp drivers.

## Interface
- NUM_DIR, 2: number of approaches, ≥2; DW = max(1, $clog2(NUM_DIR))
- CNT_W, 8: phase counter width
- G_TICKS, 20: GREEN duration in tick_en pulses, 1..2^CNT_W
- Y_TICKS, 4: YELLOW duration, 1..2^CNT_W
- R_TICKS, 2: ALL-RED clearance duration, 1..2^CNT_W
- clk  in  1  clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- tick_en  in  1  timebase strobe; counters advance only on cycles where it is 1
- sense  in  NUM_DIR  per-approach vehicle/pedestrian demand, level, sampled every cycle
- flash  in  1  night/fault mode request, level
- light  out  3*NUM_DIR  approach d at [3d+2:3d]; RED=100, GREEN=010, YELLOW=001, dark=000
- cur_dir  out  DW  approach currently owning (or last owning) right of way
- phase  out  2  0=GREEN, 1=YELLOW, 2=ALLRED, 3=FLASH

## Operation
- Registers: phase, cur_dir, cnt[CNT_W-1:0], req[NUM_DIR-1:0], fl (flash toggle).
- light is a pure decode of the registered phase, cur_dir and fl. No extra latency.
- Non-FLASH decode: approach cur_dir shows GREEN in GREEN and YELLOW in YELLOW. Every other approach, and all approaches in ALLRED, show RED.
- FLASH decode: every approach shows YELLOW when fl=1 and 000 when fl=0.
- Demand latch: req[d] is set on any cycle with sense[d]=1.
  - Exception: d==cur_dir while phase is GREEN or YELLOW; that sense is ignored.
  - req[d] is cleared on the edge where d enters GREEN. The clear wins over a simultaneous set.
- other_req = |(req with bit cur_dir masked). Uses registered req only, so sense reaches the decision 1 cycle later.
- Expiry: a phase expires on a tick_en=1 cycle with cnt == DUR-1. cnt increments on other tick_en cycles, resets to 0 on every phase change, and holds when tick_en=0.
- GREEN expiry with other_req=1 → YELLOW.
- GREEN expiry with other_req=0 → rest in GREEN. cnt holds at G_TICKS-1 and the decision is re-evaluated on every later tick_en.
- YELLOW expiry → ALLRED.
- ALLRED expiry → GREEN. cur_dir becomes the first d with req[d]=1, searching cur_dir+1, cur_dir+2, … modulo NUM_DIR, with cur_dir itself last. If req is all-zero, cur_dir becomes cur_dir+1 mod NUM_DIR.
- flash=1 on any cycle in a non-FLASH phase → FLASH on the next edge, with fl=1 and cnt=0. This overrides any same-cycle expiry.
- In FLASH, fl toggles on every tick_en=1 cycle. req keeps latching.
- flash=0 while in FLASH → ALLRED on the next edge with cnt=0, cur_dir unchanged. The normal ALLRED expiry and selection then follow.

## Timing
- Reset values: phase=ALLRED, cur_dir=NUM_DIR-1, cnt=0, req=0, fl=0. light is all approaches RED (100 each).
- Reset asserted mid-phase returns to the reset state on that edge, discarding pending req.
- With tick_en tied high, each phase lasts exactly DUR cycles.
- First GREEN after reset with no demand goes to approach 0, R_TICKS pulses after rst falls.
- Full rotation latency, all approaches demanding, tick_en=1: NUM_DIR × (G_TICKS + Y_TICKS + R_TICKS) cycles.
- At most one phase transition per edge. Priority: rst > flash entry/exit > expiry.

## Structure
- Shared package traffic_pkg holds:
  - lamp encodings LAMP_RED, LAMP_GREEN, LAMP_YELLOW, LAMP_DARK
  - the phase_t enum (GREEN, YELLOW, ALLRED, FLASH)
  - a helper function for the DW computation
- One sub-module, rr_pick: a combinational round-robin search.
  - Inputs: req, cur_dir. Outputs: next_dir, any.
  - Parametrised on NUM_DIR. Reusable by later multi-channel controllers.

## Test plan
- Reset: NUM_DIR=4, tick_en=1, sense=0, rst released.
  - Expect light=12'b100_100_100_100 and phase=2 for 2 cycles, then cur_dir=0 with light[2:0]=010.
  - With no sense asserted, approach 0 then rests in GREEN indefinitely.
- Full rotation: all sense=1 after reset, G=3, Y=2, R=1.
  - Expect approach 0 GREEN 3 cycles, YELLOW 2, ALLRED 1, then approach 1 GREEN.
  - Order 0,1,2,3,0; period 24 cycles.
- Skip: NUM_DIR=4, only sense[2] pulsed once while approach 0 is GREEN.
  - Expect 0 YELLOW, then ALLRED, then cur_dir=2 directly, skipping 1.
  - req[2] clears on that entry; approach 2 then rests in GREEN.
- Timebase gating: tick_en every 4th cycle, G=2.
  - Expect GREEN to last 8 clk cycles.
  - cnt holds between strobes.
- Flash: flash=1 mid-YELLOW.
  - Expect phase=3 next edge, all lamps 001/000 alternating per tick_en.
  - On flash=0, expect ALLRED for R_TICKS, then the next requester by round robin from the pre-flash cur_dir.
- Collisions:
  - sense[d] on the same edge d enters GREEN → req[d]=0.
  - rst=1 and flash=1 together → reset state.
  - flash=1 on an expiry cycle → FLASH, not YELLOW.

Source files
------------

// File: rtl/traffic_pkg.sv
// Shared definitions for the traffic-signal controller family:
// lamp encodings, controller phases and the direction-index width helper.
package traffic_pkg;

    localparam logic [2:0] LAMP_RED    = 3'b100;
    localparam logic [2:0] LAMP_GREEN  = 3'b010;
    localparam logic [2:0] LAMP_YELLOW = 3'b001;
    localparam logic [2:0] LAMP_DARK   = 3'b000;

    typedef enum logic [1:0] {
        GREEN  = 2'd0,
        YELLOW = 2'd1,
        ALLRED = 2'd2,
        FLASH  = 2'd3
    } phase_t;

    // Width of an approach index; never narrower than one bit.
    function automatic int calc_dw(input int num_dir);
        return (num_dir > 1) ? $clog2(num_dir) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin search: first requester after cur_dir, wrapping,
// with cur_dir itself considered last. next_dir equals cur_dir when no request.
module rr_pick
    import traffic_pkg::*;
#(
    parameter  int NUM_DIR = 2,
    localparam int DW      = calc_dw(NUM_DIR)
) (
    input  logic [NUM_DIR-1:0] req,
    input  logic [DW-1:0]      cur_dir,
    output logic [DW-1:0]      next_dir,
    output logic               any
);

    logic [DW-1:0] idx;
    logic          found;

    assign any = |req;

    // NOTE: every variable written here gets a default before the loop,
    // otherwise a path that leaves it unassigned infers a latch.
    always_comb begin
        next_dir = cur_dir;
        found    = 1'b0;
        idx      = '0;
        for (int k = 1; k <= NUM_DIR; k++) begin
            idx = DW'((int'(cur_dir) + k) % NUM_DIR);
            if (!found && req[idx]) begin
                found    = 1'b1;
                next_dir = idx;
            end
        end
    end

endmodule

// File: rtl/traffic_light_ctrl.sv
// N-approach signal controller: GREEN -> YELLOW -> ALL-RED round robin with
// demand skipping, rest-in-green and a flashing-yellow night/fault mode.
module traffic_light_ctrl
    import traffic_pkg::*;
#(
    parameter  int NUM_DIR = 2,
    parameter  int CNT_W   = 8,
    parameter  int G_TICKS = 20,
    parameter  int Y_TICKS = 4,
    parameter  int R_TICKS = 2,
    localparam int DW      = calc_dw(NUM_DIR)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick_en,
    input  logic [NUM_DIR-1:0]   sense,
    input  logic                 flash,
    output logic [3*NUM_DIR-1:0] light,
    output logic [DW-1:0]        cur_dir,
    output logic [1:0]           phase
);

    phase_t             phase_q, phase_d;
    logic [DW-1:0]      dir_q, dir_d, dir_inc, pick_dir;
    logic [CNT_W-1:0]   cnt_q, cnt_d, dur_last;
    logic [NUM_DIR-1:0] req_q, req_d, dir_mask, sense_mask;
    logic               fl_q, fl_d, pick_any, other_req, at_last;

    rr_pick #(.NUM_DIR(NUM_DIR)) u_rr_pick (
        .req      (req_q),
        .cur_dir  (dir_q),
        .next_dir (pick_dir),
        .any      (pick_any)
    );

    assign dir_mask   = {{(NUM_DIR-1){1'b0}}, 1'b1} << dir_q;
    assign sense_mask = (phase_q == GREEN || phase_q == YELLOW) ? dir_mask : '0;
    assign other_req  = |(req_q & ~dir_mask);
    assign dir_inc    = (dir_q == DW'(NUM_DIR - 1)) ? '0 : dir_q + 1'b1;

    always_comb begin
        case (phase_q)
            GREEN:   dur_last = CNT_W'(G_TICKS - 1);
            YELLOW:  dur_last = CNT_W'(Y_TICKS - 1);
            default: dur_last = CNT_W'(R_TICKS - 1);
        endcase
    end

    assign at_last = (cnt_q == dur_last);

    always_comb begin
        phase_d = phase_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        req_d   = req_q | (sense & ~sense_mask);

        // Flash entry/exit outranks any expiry on the same edge.
        if (phase_q == FLASH) begin
            if (!flash) begin
                phase_d = ALLRED;
                cnt_d   = '0;
            end else if (tick_en) begin
                fl_d = ~fl_q;
            end
        end else if (flash) begin
            phase_d = FLASH;
            fl_d    = 1'b1;
            cnt_d   = '0;
        end else if (tick_en) begin
            if (!at_last) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                case (phase_q)
                    GREEN: begin
                        if (other_req) begin
                            phase_d = YELLOW;
                            cnt_d   = '0;
                        end
                    end
                    YELLOW: begin
                        phase_d = ALLRED;
                        cnt_d   = '0;
                    end
                    default: begin
                        phase_d      = GREEN;
                        cnt_d        = '0;
                        dir_d        = pick_any ? pick_dir : dir_inc;
                        req_d[dir_d] = 1'b0;
                    end
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the values from before this edge, independent of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            phase_q <= ALLRED;
            dir_q   <= DW'(NUM_DIR - 1);
            cnt_q   <= '0;
            req_q   <= '0;
            fl_q    <= 1'b0;
        end else begin
            phase_q <= phase_d;
            dir_q   <= dir_d;
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            fl_q    <= fl_d;
        end
    end

    always_comb begin
        light = '0;
        for (int d = 0; d < NUM_DIR; d++) begin
            if (phase_q == FLASH)
                light[3*d +: 3] = fl_q ? LAMP_YELLOW : LAMP_DARK;
            else if (phase_q == GREEN && dir_q == DW'(d))
                light[3*d +: 3] = LAMP_GREEN;
            else if (phase_q == YELLOW && dir_q == DW'(d))
                light[3*d +: 3] = LAMP_YELLOW;
            else
                light[3*d +: 3] = LAMP_RED;
        end
    end

    assign cur_dir = dir_q;
    assign phase   = phase_q;

endmodule

// File: tb/tb_traffic_light_ctrl.sv
// Self-checking bench for traffic_light_ctrl: a hand-computed vector table plus
// rotation and gated-timebase sequences, all compared through a scoreboard queue.
module tb_traffic_light_ctrl;
    import traffic_pkg::*;

    localparam int ND = 4;
    localparam int CW = 4;
    localparam int GT = 3;
    localparam int YT = 2;
    localparam int RT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          tick_en = 1'b0;
    logic          flash = 1'b0;
    logic [ND-1:0] sense = '0;
    logic [3*ND-1:0] light;
    logic [1:0]    cur_dir;
    logic [1:0]    phase;

    always #5 clk = ~clk;

    traffic_light_ctrl #(
        .NUM_DIR (ND),
        .CNT_W   (CW),
        .G_TICKS (GT),
        .Y_TICKS (YT),
        .R_TICKS (RT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .tick_en (tick_en),
        .sense   (sense),
        .flash   (flash),
        .light   (light),
        .cur_dir (cur_dir),
        .phase   (phase)
    );

    typedef struct {
        logic       rst;
        logic       tick;
        logic       flash;
        logic [3:0] sense;
        logic [1:0] ph;
        logic [1:0] dir;
        logic       fl;
    } vec_t;

    typedef struct {
        logic [1:0]  ph;
        logic [1:0]  dir;
        logic [11:0] light;
        string       name;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;

    function automatic vec_t mkv(logic r, logic t, logic f, logic [3:0] s,
                                 logic [1:0] p, logic [1:0] d, logic l);
        vec_t v;
        v.rst = r; v.tick = t; v.flash = f; v.sense = s;
        v.ph = p; v.dir = d; v.fl = l;
        return v;
    endfunction

    function automatic logic [11:0] lamps(logic [1:0] p, logic [1:0] d, logic l);
        logic [11:0] r;
        r = '0;
        for (int i = 0; i < ND; i++) begin
            if (p == 2'd3)                    r[3*i +: 3] = l ? 3'b001 : 3'b000;
            else if (p == 2'd0 && d == 2'(i)) r[3*i +: 3] = 3'b010;
            else if (p == 2'd1 && d == 2'(i)) r[3*i +: 3] = 3'b001;
            else                              r[3*i +: 3] = 3'b100;
        end
        return r;
    endfunction

    task automatic check(string name, logic [11:0] act, logic [11:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %b want %b", name, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, sample after the edge.
    task automatic step(logic r, logic t, logic f, logic [3:0] s,
                        logic [1:0] p, logic [1:0] d, logic l, string name);
        exp_t e;
        rst = r; tick_en = t; flash = f; sense = s;
        e.ph = p; e.dir = d; e.light = lamps(p, d, l); e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        e = sb.pop_front();
        check({e.name, ".phase"}, {10'd0, phase}, {10'd0, e.ph});
        check({e.name, ".dir"},   {10'd0, cur_dir}, {10'd0, e.dir});
        check({e.name, ".light"}, light, e.light);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        // rst tick flash sense ph dir fl
        vecs.push_back(mkv(1, 1, 0, 4'b0000, 2, 3, 0)); // reset state
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 3, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0)); // first green to 0
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0100, 0, 0, 0)); // pulse sense[2]
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0100, 0, 2, 0)); // skip 1; sense on entry edge
        for (int i = 0; i < 4; i++) vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b1000, 0, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 2, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 3, 0));
        for (int i = 0; i < 5; i++) vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 3, 0)); // req[2] must be clear
        vecs.push_back(mkv(0, 1, 0, 4'b0001, 0, 3, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 3, 0));
        vecs.push_back(mkv(0, 1, 1, 4'b0010, 3, 3, 1)); // flash mid-yellow
        vecs.push_back(mkv(0, 1, 1, 4'b0000, 3, 3, 0));
        vecs.push_back(mkv(0, 0, 1, 4'b0000, 3, 3, 0));
        vecs.push_back(mkv(0, 1, 1, 4'b0000, 3, 3, 1));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 3, 0)); // flash exit
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 3, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 1, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 0, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0100, 0, 1, 0));
        vecs.push_back(mkv(0, 1, 1, 4'b0000, 3, 1, 1)); // flash on expiry cycle
        vecs.push_back(mkv(0, 0, 1, 4'b0000, 3, 1, 1));
        vecs.push_back(mkv(1, 1, 1, 4'b0000, 2, 3, 0)); // rst with flash
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 2, 3, 0));
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0)); // pending req[2] discarded
        vecs.push_back(mkv(0, 1, 0, 4'b0000, 0, 0, 0));

        for (int i = 0; i < vecs.size(); i++)
            step(vecs[i].rst, vecs[i].tick, vecs[i].flash, vecs[i].sense,
                 vecs[i].ph, vecs[i].dir, vecs[i].fl, $sformatf("vec%0d", i));

        // Full rotation, all approaches demanding: period ND*(GT+YT+RT) cycles.
        step(1, 1, 0, 4'b1111, 2, 3, 0, "rot_rst");
        for (int t = 0; t < 1 + ND * (GT + YT + RT) + 8; t++) begin
            logic [1:0] p, d;
            int u, w;
            if (t == 0) begin
                p = 2; d = 3;
            end else begin
                u = t - 1;
                w = u % (GT + YT + RT);
                d = 2'((u / (GT + YT + RT)) % ND);
                p = (w < GT) ? 2'd0 : (w < GT + YT) ? 2'd1 : 2'd2;
            end
            step(0, 1, 0, 4'b1111, p, d, 0, $sformatf("rot%0d", t));
        end

        // Timebase gated to every 4th cycle: phases stretch by 4x, cnt holds between.
        step(1, 0, 0, 4'b1111, 2, 3, 0, "gate_rst");
        for (int i = 0; i < 20; i++) begin
            logic [1:0] p, d;
            if (i < 4 * RT - 1)            begin p = 2; d = 3; end
            else if (i < 4 * (RT + GT) - 1) begin p = 0; d = 0; end
            else                            begin p = 1; d = 0; end
            step(0, (i % 4 == 3), 0, 4'b1111, p, d, 0, $sformatf("gate%0d", i));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
